pingpong_banked: RTL and testbench

PINGPONG_BANKED -- requirements
Module: pingpong_banked

---
 rtl/pingpong_banked_pkg.sv | 19 +
 rtl/pingpong_bank.sv | 53 +++++
 rtl/pingpong_banked.sv | 113 +++++++++++
 tb/tb_pingpong_banked.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_banked_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pingpong_banked_pkg : index/count width helpers for the bank buffer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pingpong_banked_pkg;

   // Index width into n entries; never narrower than one bit.
   function automatic int idx_wd(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width able to hold the values 0..n inclusive.
   function automatic int cnt_wd(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pingpong_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pingpong_bank : one bank of storage with its commit flag and length |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pingpong_bank
   import pingpong_banked_pkg::*;
#(
   parameter  int BANK_DEPTH = 4,
   parameter  int DATA_WD    = 8,
   localparam int IDX_WD     = idx_wd(BANK_DEPTH)
)(
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_wr_en,
   input  logic [IDX_WD-1:0]  i_wr_idx,
   input  logic [DATA_WD-1:0] i_wr_data,
   input  logic               i_commit,
   input  logic               i_release,
   input  logic [IDX_WD-1:0]  i_rd_idx,
   output logic [DATA_WD-1:0] o_rd_data,
   output logic               o_committed,
   output logic [IDX_WD-1:0]  o_last_idx
);

   logic [DATA_WD-1:0] r_mem [BANK_DEPTH];
   logic               r_committed;
   logic [IDX_WD-1:0]  r_last_idx;

   always_ff @(posedge clk) begin
      if (i_wr_en)
         r_mem[i_wr_idx] <= i_wr_data;
   end

   // The committing write is the last word, so its index is the stored length-1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_committed <= 1'b0;
         r_last_idx  <= '0;
      end else if (i_commit) begin
         r_committed <= 1'b1;
         r_last_idx  <= i_wr_idx;
      end else if (i_release) begin
         r_committed <= 1'b0;
      end
   end

   assign o_rd_data   = r_mem[i_rd_idx];
   assign o_committed = r_committed;
   assign o_last_idx  = r_last_idx;

endmodule
`default_nettype wire

// File: rtl/pingpong_banked.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pingpong_banked : N-bank ping-pong buffer, drained in commit order  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pingpong_banked
   import pingpong_banked_pkg::*;
#(
   parameter  int BANK_NUM   = 2,
   parameter  int BANK_DEPTH = 4,
   parameter  int DATA_WD    = 8,
   localparam int CNT_WD     = cnt_wd(BANK_NUM)
)(
   input  logic               clk,
   input  logic               rstn,
   input  logic               valid_in,
   input  logic [DATA_WD-1:0] data_in,
   input  logic               last_in,
   output logic               ready_in,
   output logic               valid_out,
   output logic [DATA_WD-1:0] data_out,
   output logic               last_out,
   input  logic               ready_out,
   output logic [CNT_WD-1:0]  bank_cnt
);

   localparam int PTR_WD = idx_wd(BANK_NUM);
   localparam int IDX_WD = idx_wd(BANK_DEPTH);

   logic [PTR_WD-1:0] r_wptr;
   logic [IDX_WD-1:0] r_widx;
   logic [PTR_WD-1:0] r_rptr;
   logic [IDX_WD-1:0] r_ridx;
   logic [CNT_WD-1:0] r_bank_cnt;

   logic               w_committed [BANK_NUM];
   logic [DATA_WD-1:0] w_rd_data   [BANK_NUM];
   logic [IDX_WD-1:0]  w_last_idx  [BANK_NUM];

   logic w_wr_fire;
   logic w_rd_fire;
   logic w_commit;
   logic w_release;

   function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
      return (p == PTR_WD'(BANK_NUM - 1)) ? '0 : p + 1'b1;
   endfunction

   // Readiness comes from registered commit flags only, so a bank freed this
   // cycle is not refilled until the next one.
   assign ready_in  = ~w_committed[r_wptr];
   assign valid_out = w_committed[r_rptr];
   assign last_out  = valid_out && (r_ridx == w_last_idx[r_rptr]);
   assign data_out  = valid_out ? w_rd_data[r_rptr] : '0;
   assign bank_cnt  = r_bank_cnt;

   assign w_wr_fire = valid_in && ready_in;
   assign w_rd_fire = valid_out && ready_out;
   assign w_commit  = w_wr_fire && (last_in || (r_widx == IDX_WD'(BANK_DEPTH - 1)));
   assign w_release = w_rd_fire && last_out;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr     <= '0;
         r_widx     <= '0;
         r_rptr     <= '0;
         r_ridx     <= '0;
         r_bank_cnt <= '0;
      end else begin
         if (w_wr_fire) begin
            if (w_commit) begin
               r_widx <= '0;
               r_wptr <= ptr_inc(r_wptr);
            end else begin
               r_widx <= r_widx + 1'b1;
            end
         end
         if (w_rd_fire) begin
            if (w_release) begin
               r_ridx <= '0;
               r_rptr <= ptr_inc(r_rptr);
            end else begin
               r_ridx <= r_ridx + 1'b1;
            end
         end
         if (w_commit && !w_release)
            r_bank_cnt <= r_bank_cnt + 1'b1;
         else if (w_release && !w_commit)
            r_bank_cnt <= r_bank_cnt - 1'b1;
      end
   end

   for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
      pingpong_bank #(
         .BANK_DEPTH (BANK_DEPTH),
         .DATA_WD    (DATA_WD)
      ) u_bank (
         .clk         (clk),
         .rstn        (rstn),
         .i_wr_en     (w_wr_fire && (r_wptr == PTR_WD'(g))),
         .i_wr_idx    (r_widx),
         .i_wr_data   (data_in),
         .i_commit    (w_commit && (r_wptr == PTR_WD'(g))),
         .i_release   (w_release && (r_rptr == PTR_WD'(g))),
         .i_rd_idx    (r_ridx),
         .o_rd_data   (w_rd_data[g]),
         .o_committed (w_committed[g]),
         .o_last_idx  (w_last_idx[g])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_pingpong_banked.sv
`default_nettype none
// Bench for pingpong_banked: instance A uses defaults, instance B uses 3 banks of depth 1.
module tb_pingpong_banked;

   logic       clk = 1'b0;
   logic       rstn;
   logic       vin  [2];
   logic       lin  [2];
   logic       rout [2];
   logic [7:0] din  [2];
   logic       o_rdy  [2];
   logic       o_vld  [2];
   logic       o_last [2];
   logic [7:0] o_data [2];
   logic [1:0] o_cnt  [2];

   int n_checks = 0;
   int n_fail   = 0;
   int a_wfires = 0;
   int a_max_cnt = 0;

   int m_words [2][$];
   int m_lens  [2][$];
   int m_part  [2][$];
   int lg      [2][$];

   always #5 clk = ~clk;

   pingpong_banked #(.BANK_NUM(2), .BANK_DEPTH(4), .DATA_WD(8)) u_dut_a (
      .clk(clk), .rstn(rstn),
      .valid_in(vin[0]), .data_in(din[0]), .last_in(lin[0]), .ready_in(o_rdy[0]),
      .valid_out(o_vld[0]), .data_out(o_data[0]), .last_out(o_last[0]),
      .ready_out(rout[0]), .bank_cnt(o_cnt[0])
   );

   pingpong_banked #(.BANK_NUM(3), .BANK_DEPTH(1), .DATA_WD(8)) u_dut_b (
      .clk(clk), .rstn(rstn),
      .valid_in(vin[1]), .data_in(din[1]), .last_in(lin[1]), .ready_in(o_rdy[1]),
      .valid_out(o_vld[1]), .data_out(o_data[1]), .last_out(o_last[1]),
      .ready_out(rout[1]), .bank_cnt(o_cnt[1])
   );

   function automatic int bn(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   function automatic int bd(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: committed blocks as a word queue plus per-block remaining counts.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 2; k++) begin
            m_words[k].delete();
            m_lens[k].delete();
            m_part[k].delete();
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            automatic bit wf = vin[k] && (m_lens[k].size() < bn(k));
            automatic bit rf = rout[k] && (m_lens[k].size() > 0);
            if (rf) begin
               void'(m_words[k].pop_front());
               m_lens[k][0] = m_lens[k][0] - 1;
               if (m_lens[k][0] == 0) void'(m_lens[k].pop_front());
            end
            if (wf) begin
               m_part[k].push_back(int'(din[k]));
               if (lin[k] || m_part[k].size() == bd(k)) begin
                  m_lens[k].push_back(m_part[k].size());
                  foreach (m_part[k][j]) m_words[k].push_back(m_part[k][j]);
                  m_part[k].delete();
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         automatic int c = m_lens[k].size();
         automatic bit v = (c > 0);
         chk($sformatf("ready_in[%0d]", k),  int'(o_rdy[k]),  int'(c < bn(k)));
         chk($sformatf("valid_out[%0d]", k), int'(o_vld[k]),  int'(v));
         chk($sformatf("data_out[%0d]", k),  int'(o_data[k]), v ? m_words[k][0] : 0);
         chk($sformatf("last_out[%0d]", k),  int'(o_last[k]), int'(v && m_lens[k][0] == 1));
         chk($sformatf("bank_cnt[%0d]", k),  int'(o_cnt[k]),  c);
         if (o_vld[k] && rout[k]) lg[k].push_back(int'(o_data[k]) + (o_last[k] ? 256 : 0));
      end
      if (int'(o_cnt[0]) > a_max_cnt) a_max_cnt = int'(o_cnt[0]);
   end

   task automatic send_a(input int v, input bit last, output int cyc);
      bit r;
      vin[0] = 1'b1; din[0] = v[7:0]; lin[0] = last;
      cyc = 0;
      do begin
         @(negedge clk); r = o_rdy[0];
         @(posedge clk); #1; cyc++;
      end while (!r && cyc < 200);
      if (!r) chk("send_timeout", 0, 1);
      else a_wfires++;
      vin[0] = 1'b0; lin[0] = 1'b0;
   endtask

   task automatic drain(input int k);
      int n;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while ((o_cnt[k] != 0 || o_vld[k]) && n < 300);
      if (n >= 300) chk("drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_log_a(input string name, input int exp_q[$]);
      chk({name, "_count"}, lg[0].size(), exp_q.size());
      foreach (exp_q[j])
         if (j < lg[0].size()) chk($sformatf("%s_word%0d", name, j), lg[0][j], exp_q[j]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int cyc, nxt, n;
      bit r, found;
      for (int k = 0; k < 2; k++) begin
         vin[k] = 0; lin[k] = 0; rout[k] = 0; din[k] = '0;
      end
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready_in",  int'(o_rdy[0]),  1);
      chk("rst_valid_out", int'(o_vld[0]),  0);
      chk("rst_data_out",  int'(o_data[0]), 0);
      chk("rst_last_out",  int'(o_last[0]), 0);
      chk("rst_bank_cnt",  int'(o_cnt[0]),  0);
      rstn = 1'b1;

      // Continuous 0..7 with a free-running reader.
      rout[0] = 1; a_max_cnt = 0; lg[0].delete();
      for (int i = 0; i < 8; i++) begin
         send_a(i, 1'b0, cyc);
         if (i == 0) chk("first_fire_cycles", cyc, 1);
      end
      drain(0);
      check_log_a("seq8", '{0, 1, 2, 259, 4, 5, 6, 263});
      chk("max_bank_cnt_le2", int'(a_max_cnt <= 2), 1);

      // Fill both banks with the reader stalled, then release.
      lg[0].delete(); rout[0] = 0; a_wfires = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) send_a(i, i == 9, cyc);
         end
         begin
            n = 0;
            while (a_wfires < 8 && n < 100) begin @(posedge clk); #1; n++; end
            chk("eight_fires_seen", int'(a_wfires >= 8), 1);
            @(negedge clk);
            chk("full_ready_in", int'(o_rdy[0]), 0);
            chk("full_bank_cnt", int'(o_cnt[0]), 2);
            repeat (3) @(negedge clk);
            chk("full_hold_ready_in", int'(o_rdy[0]), 0);
            @(posedge clk); #1; rout[0] = 1;
            found = 0;
            for (int c = 0; c < 50 && !found; c++) begin
               @(negedge clk);
               if (o_vld[0] && o_last[0] && o_data[0] == 8'd3) begin
                  chk("ready_at_release", int'(o_rdy[0]), 0);
                  @(negedge clk);
                  chk("ready_after_release", int'(o_rdy[0]), 1);
                  found = 1;
               end
            end
            if (!found) chk("release_seen", 0, 1);
         end
      join
      drain(0);
      check_log_a("full10", '{0, 1, 2, 259, 4, 5, 6, 263, 8, 265});

      // Early commit via last_in.
      lg[0].delete(); rout[0] = 1;
      send_a(5, 1'b0, cyc); send_a(6, 1'b1, cyc);
      for (int i = 7; i <= 10; i++) send_a(i, 1'b0, cyc);
      drain(0);
      check_log_a("early", '{5, 262, 7, 8, 9, 266});

      // Asynchronous reset with one committed and one partial bank.
      rout[0] = 0;
      for (int i = 20; i < 26; i++) send_a(i, 1'b0, cyc);
      #2 rstn = 1'b0;
      #1;
      chk("arst_ready_in",  int'(o_rdy[0]),  1);
      chk("arst_valid_out", int'(o_vld[0]),  0);
      chk("arst_data_out",  int'(o_data[0]), 0);
      chk("arst_last_out",  int'(o_last[0]), 0);
      chk("arst_bank_cnt",  int'(o_cnt[0]),  0);
      @(posedge clk); #1; rstn = 1'b1;
      lg[0].delete(); rout[0] = 1;
      for (int i = 0; i < 4; i++) send_a(i, 1'b0, cyc);
      drain(0);
      check_log_a("post_rst", '{0, 1, 2, 259});

      // Instance B: random handshakes, depth-1 banks.
      lg[1].delete(); nxt = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk); r = o_rdy[1];
         @(posedge clk);
         if (vin[1] && r) nxt++;
         #1;
         vin[1]  = 1'($urandom_range(0, 1));
         din[1]  = nxt[7:0];
         lin[1]  = 1'($urandom_range(0, 1));
         rout[1] = 1'($urandom_range(0, 1));
      end
      vin[1] = 0; rout[1] = 1;
      drain(1);
      chk("b_enough_words", int'(nxt > 20), 1);
      chk("b_count", lg[1].size(), nxt);
      foreach (lg[1][j]) chk($sformatf("b_word%0d", j), lg[1][j], (j & 255) + 256);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
